// File: rtl/ii_schedule_checker.sv
// Checks that a stream of valid pulses follows an initiation-interval schedule
// relative to a start pulse; reports progress, completion and the first violation.
module ii_schedule_checker #(
    parameter int N       = 2,
    parameter int II      = 1,
    parameter int LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic [31:0] iter_idx,
    output logic        last,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    localparam logic [1:0]  CODE_NONE    = 2'b00;
    localparam logic [1:0]  CODE_EARLY   = 2'b01;
    localparam logic [1:0]  CODE_MISSING = 2'b10;
    localparam logic [1:0]  CODE_EXTRA   = 2'b11;
    localparam logic [31:0] N_W          = 32'(N);
    localparam logic [31:0] II_W         = 32'(II);
    localparam logic [31:0] LAT_W        = 32'(LATENCY);

    state_t      state_reg;
    logic [31:0] iter_idx_reg;
    logic [31:0] wait_reg;
    logic        done_reg;
    logic        err_reg;
    logic [1:0]  err_code_reg;

    logic        start_eff;
    logic        in_txn;
    logic        slot_now;
    logic        accept;
    logic        final_accept;
    logic [31:0] base_idx;
    logic [1:0]  viol_code;

    // The counter register holds cycles left after this one, so loads are
    // the nominal distance minus one; zero marks the slot cycle.
    always_comb begin
        start_eff    = start && (state_reg != ST_ERR);
        in_txn       = start_eff || (state_reg == ST_ARMED);
        slot_now     = start_eff ? (LAT_W == 32'd0)
                                 : ((state_reg == ST_ARMED) && (wait_reg == 32'd0));
        base_idx     = start_eff ? 32'd0 : iter_idx_reg;
        accept       = in_txn && slot_now && in_valid;
        final_accept = accept && ((base_idx + 32'd1) == N_W);
        viol_code    = CODE_NONE;
        if (in_txn) begin
            if (slot_now && !in_valid)
                viol_code = CODE_MISSING;
            else if (!slot_now && in_valid)
                viol_code = CODE_EARLY;
        end else if (((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && in_valid) begin
            viol_code = CODE_EXTRA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            iter_idx_reg <= 32'd0;
            wait_reg     <= 32'd0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= CODE_NONE;
        end else if (viol_code != CODE_NONE) begin
            state_reg    <= ST_ERR;
            err_reg      <= 1'b1;
            err_code_reg <= viol_code;
            if (start_eff) begin
                iter_idx_reg <= 32'd0;
                done_reg     <= 1'b0;
            end
        end else if (accept) begin
            iter_idx_reg <= base_idx + 32'd1;
            wait_reg     <= II_W - 32'd1;
            if (final_accept) begin
                state_reg <= ST_DONE;
                done_reg  <= 1'b1;
            end else begin
                state_reg <= ST_ARMED;
                done_reg  <= 1'b0;
            end
        end else if (start_eff) begin
            // Only reachable with LATENCY > 0: a zero-latency start must accept or fail.
            state_reg    <= ST_ARMED;
            iter_idx_reg <= 32'd0;
            done_reg     <= 1'b0;
            wait_reg     <= LAT_W - 32'd1;
        end else if (state_reg == ST_ARMED) begin
            wait_reg <= wait_reg - 32'd1;
        end
    end

    assign iter_idx = iter_idx_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign err_code = err_code_reg;
    assign last     = final_accept && !rst;

endmodule
